oam_dma_master: RTL and testbench
=================================

Name: oam_dma_master

Overview:
- Bus initiator for the 8-bit CPU address/data bus. It is the requesting end of the cs_n/rw_n protocol that the 64K RAM responder and the PPU register port answer to.
- Implements the NES sprite DMA triggered by a CPU write to $4014. It halts the CPU, then copies XFER_LEN bytes from CPU page {page,8'h00} into the PPU OAM data port at DEST_ADDR.
- Sits beside the CPU core. The top level muxes this block's bus outputs onto the shared bus while cpu_halt=1.

Parameters:
- DEST_ADDR, 16'h2004, bus address written once per transferred byte (OAMDATA).
- XFER_LEN, 256, number of bytes per transfer; legal range 1..256.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle trigger, sampled on rising edge.
- page  input  8  source page (high address byte); latched when start is accepted.
- bus_addr  output  16  bus address.
- bus_cs_n  output  1  chip select, active low.
- bus_rw_n  output  1  1=read, 0=write.
- bus_data_in  input  8  read data from the bus.
- bus_data_out  output  8  write data.
- bus_data_oe  output  1  1 = top level drives bus_data_out onto the tri-state data bus.
- busy  output  1  transfer in progress.
- cpu_halt  output  1  CPU stall request; identical to busy.
- done  output  1  one-cycle pulse after the last write.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high (rst), sampled on rising edge of clk. All outputs are registered.
- Reset/idle output values: bus_addr=16'h0000, bus_cs_n=1, bus_rw_n=1, bus_data_out=8'h00, bus_data_oe=0, busy=0, cpu_halt=0, done=0. Internal byte counter=0, latched page=0.
- Bus protocol (matches the responder's registered read):
  - Read: initiator holds addr, cs_n=0, rw_n=1 for two cycles. The responder registers data at the end of the first cycle and drives it during the second. The initiator captures bus_data_in at the rising edge ending the second cycle.
  - Write: a single cycle with addr, data, cs_n=0, rw_n=0, oe=1. The responder samples at the rising edge ending that cycle.
- FSM states: IDLE, HALT, RD, RD_WAIT, WR.
  - IDLE -> HALT when start=1: latch page, clear counter, busy=1. bus_cs_n stays 1 in HALT. HALT is a one-cycle alignment slot.
  - HALT -> RD.
  - RD: bus_addr={page_q,cnt[7:0]}, cs_n=0, rw_n=1, oe=0. RD -> RD_WAIT.
  - RD_WAIT: same bus values as RD. Capture bus_data_in into the data register at exit. RD_WAIT -> WR.
  - WR: bus_addr=DEST_ADDR, bus_data_out=captured byte, oe=1, cs_n=0, rw_n=0.
  - If cnt==XFER_LEN-1: WR -> IDLE with done=1 and busy=0 in the following cycle. Otherwise cnt+1 and WR -> RD.
- Timing: 3 cycles per byte. busy is high for 1 + 3*XFER_LEN cycles (769 at default). done is high exactly one cycle, in the first IDLE cycle.
- Counter is 9 bits wide. Only cnt[7:0] forms the address, so page 8'hFF reads $FF00..$FFFF with no carry out. Source addresses never leave the latched page.
- start while busy is ignored: no restart, no page re-latch.
- start in the same cycle that done=1 is accepted; HALT follows immediately.
- page changes after acceptance have no effect.
- bus_data_oe is 1 only in WR, so there is never bus contention during reads.
- rst mid-transfer: next edge returns to IDLE with reset output values. No done pulse and no partial write completion. A cycle where rst=1 and start=1 stays in IDLE.

Test Plan:
- Basic: RAM[$0200+i]=i^8'h5A; pulse start with page=8'h02. Expect:
  - 256 writes to $2004 with data i^8'h5A in order, i=0..255;
  - reads at $0200..$02FF;
  - busy high 769 cycles; done exactly once, on cycle 770 after start.
- Page wrap: page=8'hFF, RAM[$FFxx]=~xx. Expect last read at $FFFF, data 8'h00 to $2004, then IDLE. No access to $0000.
- Start while busy: second start with page=8'h05 at byte 10. Expect it ignored; all reads stay in page $02; a single done.
- Reset mid-transfer: rst at byte 100 in the WR cycle. Expect next cycle cs_n=1, rw_n=1, oe=0, busy=0, done=0. A new start then restarts at $xx00.
- Back-to-back: start asserted on the done cycle. Expect HALT next cycle, a second full transfer, and two done pulses 770 cycles apart.
- XFER_LEN=4, DEST_ADDR=16'h3000: expect 4 writes to $3000, busy high 13 cycles.

Source files
------------

// File: rtl/oam_dma_master_if.sv
// CPU-side 8-bit bus between an initiator (master) and a responder (slave).
// Read data comes back one cycle after the address (registered responder).
interface oam_dma_master_if;
   logic [15:0] bus_addr;
   logic        bus_cs_n;
   logic        bus_rw_n;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_data_out;
   logic        bus_data_oe;

   modport master (
      output bus_addr, bus_cs_n, bus_rw_n, bus_data_out, bus_data_oe,
      input  bus_data_in
   );

   modport slave (
      input  bus_addr, bus_cs_n, bus_rw_n, bus_data_out, bus_data_oe,
      output bus_data_in
   );
endinterface

// File: rtl/oam_dma_master.sv
// NES sprite DMA: halts the CPU and copies XFER_LEN bytes from page {page,8'h00}
// into the PPU OAM data port, 3 bus cycles per byte (read, read-wait, write).
module oam_dma_master #(
   parameter logic [15:0] DEST_ADDR = 16'h2004,
   parameter int          XFER_LEN  = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               page,
   oam_dma_master_if.master         bus,
   output logic                     busy,
   output logic                     cpu_halt,
   output logic                     done
);

   typedef enum logic [2:0] {IDLE, HALT, RD, RD_WAIT, WR} state_t;

   localparam logic [8:0] LAST = 9'(XFER_LEN - 1);

   state_t      r_state;
   logic [8:0]  r_cnt;
   logic [7:0]  r_page;
   logic [15:0] r_addr;
   logic        r_cs_n;
   logic        r_rw_n;
   logic [7:0]  r_data;
   logic        r_oe;
   logic        r_busy;
   logic        r_done;
   logic [8:0]  w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + 9'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_page  <= '0;
         r_addr  <= '0;
         r_cs_n  <= 1'b1;
         r_rw_n  <= 1'b1;
         r_data  <= '0;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= HALT;
                  r_page  <= page;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            HALT: begin
               r_state <= RD;
               r_addr  <= {r_page, r_cnt[7:0]};
               r_cs_n  <= 1'b0;
               r_rw_n  <= 1'b1;
            end
            RD: r_state <= RD_WAIT;
            RD_WAIT: begin
               // responder drives the byte during this second read cycle
               r_state <= WR;
               r_addr  <= DEST_ADDR;
               r_data  <= bus.bus_data_in;
               r_oe    <= 1'b1;
               r_rw_n  <= 1'b0;
            end
            WR: begin
               r_oe   <= 1'b0;
               r_rw_n <= 1'b1;
               r_data <= '0;
               if (r_cnt == LAST) begin
                  r_state <= IDLE;
                  r_addr  <= '0;
                  r_cs_n  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  // only the low byte addresses the source, so no page carry
                  r_state <= RD;
                  r_cnt   <= w_cnt_nxt;
                  r_addr  <= {r_page, w_cnt_nxt[7:0]};
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.bus_addr     = r_addr;
   assign bus.bus_cs_n     = r_cs_n;
   assign bus.bus_rw_n     = r_rw_n;
   assign bus.bus_data_out = r_data;
   assign bus.bus_data_oe  = r_oe;
   assign busy             = r_busy;
   assign cpu_halt         = r_busy;
   assign done             = r_done;

endmodule

// File: tb/tb_oam_dma_master.sv
// Scoreboard bench for oam_dma_master: a cycle-indexed reference model predicts
// busy/done and the read/write sequence; a negedge monitor checks the DUT bus.
module tb_oam_dma_master;
   localparam int N    = 256;
   localparam int MAXC = 16384;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, start2 = 1'b0;
   logic [7:0] page = 8'h00, page2 = 8'h00;
   logic       busy, cpu_halt, done, busy2, halt2, done2;

   oam_dma_master_if b1();
   oam_dma_master_if b2();

   oam_dma_master dut (
      .clk(clk), .rst(rst), .start(start), .page(page), .bus(b1.master),
      .busy(busy), .cpu_halt(cpu_halt), .done(done)
   );

   oam_dma_master #(.DEST_ADDR(16'h3000), .XFER_LEN(4)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .page(page2), .bus(b2.master),
      .busy(busy2), .cpu_halt(halt2), .done(done2)
   );

   always #5 clk = ~clk;

   // 64K RAM responder with registered read data
   logic [7:0] mem [0:65535];
   logic [7:0] rd1 = 8'h00, rd2 = 8'h00;
   always @(posedge clk) begin
      if (!b1.bus_cs_n && b1.bus_rw_n) rd1 <= mem[b1.bus_addr];
      if (!b2.bus_cs_n && b2.bus_rw_n) rd2 <= mem[b2.bus_addr];
   end
   assign b1.bus_data_in = rd1;
   assign b2.bus_data_in = rd2;

   int nvec = 0, nerr = 0;
   int cyc = 0;
   bit mon_on = 1'b0;
   bit exp_busy [MAXC];
   bit exp_done [MAXC];
   logic [15:0] rdq[$];
   logic [7:0]  wrq[$];
   logic [7:0]  wq2[$];
   logic [7:0]  exp_p2 = 8'h00;
   int rdcnt = 0;
   int b2cnt = 0, w2cnt = 0, d2cnt = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   // Model: a start in cycle k is taken unless cycle k is a busy cycle; busy then
   // covers k+1..k+1+3N and done lands in the cycle after.
   task automatic do_start(input logic [7:0] p);
      int k;
      k = cyc;
      page  = p;
      start = 1'b1;
      if (!exp_busy[k]) begin
         for (int c = k + 1; c <= k + 1 + 3 * N; c++) exp_busy[c] = 1'b1;
         exp_done[k + 2 + 3 * N] = 1'b1;
         for (int i = 0; i < N; i++) begin
            rdq.push_back({p, 8'(i)});
            wrq.push_back(mem[{p, 8'(i)}]);
         end
      end
      tick();
      start = 1'b0;
      page  = 8'($urandom);
   endtask

   task automatic do_reset();
      int k;
      k = cyc;
      rst = 1'b1;
      for (int c = k + 1; c < k + 4 * N && c < MAXC; c++) begin
         exp_busy[c] = 1'b0;
         exp_done[c] = 1'b0;
      end
      tick();
      rdq.delete();
      wrq.delete();
      rdcnt = 0;
      rst = 1'b0;
   endtask

   task automatic fill_rand(input logic [7:0] p);
      for (int i = 0; i < N; i++) mem[{p, 8'(i)}] = 8'($urandom);
   endtask

   // main DUT monitor
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            chk("busy", busy, exp_busy[cyc]);
            chk("cpu_halt", cpu_halt, exp_busy[cyc]);
            chk("done", done, exp_done[cyc]);
            if (b1.bus_cs_n) begin
               if (!exp_busy[cyc])
                  chk("idle_bus", {b1.bus_addr, b1.bus_rw_n, b1.bus_data_oe, b1.bus_data_out},
                      {16'h0000, 1'b1, 1'b0, 8'h00});
            end else if (b1.bus_rw_n) begin
               if (rdq.size() == 0) chk("rd_unexpected", rdq.size(), 1);
               else chk("rd_addr", b1.bus_addr, rdq[0]);
               chk("rd_oe", b1.bus_data_oe, 0);
               rdcnt++;
            end else begin
               if (wrq.size() == 0) chk("wr_unexpected", wrq.size(), 1);
               else begin
                  chk("wr_addr", b1.bus_addr, 16'h2004);
                  chk("wr_data", b1.bus_data_out, wrq[0]);
                  chk("wr_oe", b1.bus_data_oe, 1);
                  chk("rd_cycles", rdcnt, 2);
                  void'(rdq.pop_front());
                  void'(wrq.pop_front());
               end
               rdcnt = 0;
            end
         end
      end
   end

   // short-transfer DUT monitor
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (busy2) b2cnt++;
            if (done2) d2cnt++;
            if (!b2.bus_cs_n && b2.bus_rw_n) chk("d2_rd_page", b2.bus_addr[15:8], exp_p2);
            if (!b2.bus_cs_n && !b2.bus_rw_n) begin
               chk("d2_wr_addr", b2.bus_addr, 16'h3000);
               if (wq2.size() == 0) chk("d2_wr_unexpected", wq2.size(), 1);
               else chk("d2_wr_data", b2.bus_data_out, wq2.pop_front());
               w2cnt++;
            end
         end
      end
   end

   initial begin
      int lo;
      logic [7:0] p;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      tick();
      mon_on = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // basic copy from page $02
      for (int i = 0; i < N; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      do_start(8'h02);
      run_to(cyc + 3 * N + 10);

      // page $FF: last source byte is $FFFF, never wraps to $0000
      for (int i = 0; i < N; i++) mem[{8'hFF, 8'(i)}] = ~8'(i);
      do_start(8'hFF);
      run_to(cyc + 3 * N + 10);

      // start while busy is ignored
      fill_rand(8'h02);
      do_start(8'h02);
      lo = cyc;
      run_to(lo + 1 + 30);
      do_start(8'h05);
      run_to(lo + 3 * N + 10);

      // reset during the write of byte 100, then a fresh transfer
      p = 8'($urandom);
      fill_rand(p);
      do_start(p);
      lo = cyc;
      run_to(lo + 3 + 300);
      do_reset();
      run_to(cyc + 3);
      p = 8'($urandom);
      fill_rand(p);
      do_start(p);
      run_to(cyc + 3 * N + 10);

      // back-to-back: second start lands on the done cycle
      p = 8'($urandom);
      fill_rand(p);
      do_start(p);
      lo = cyc;
      run_to(lo + 1 + 3 * N);
      p = 8'($urandom);
      fill_rand(p);
      do_start(p);
      run_to(cyc + 3 * N + 10);

      // random pages and start spacing
      for (int r = 0; r < 3; r++) begin
         p = 8'($urandom);
         fill_rand(p);
         do_start(p);
         run_to(cyc + $urandom_range(700, 800));
      end
      run_to(cyc + 3 * N + 10);
      chk("rdq_drained", rdq.size(), 0);
      chk("wrq_drained", wrq.size(), 0);

      // XFER_LEN=4, DEST_ADDR=$3000 instance
      exp_p2 = 8'($urandom);
      for (int i = 0; i < 4; i++) wq2.push_back(mem[{exp_p2, 8'(i)}]);
      b2cnt = 0; w2cnt = 0; d2cnt = 0;
      page2  = exp_p2;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      page2  = ~exp_p2;
      run_to(cyc + 25);
      chk("d2_busy_cycles", b2cnt, 13);
      chk("d2_writes", w2cnt, 4);
      chk("d2_done_pulses", d2cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
